// File: rtl/tile_transposer.sv
// tile_transposer: stream-side tile transposer.
// Row beats are written into NBANK round-robin banks. Each bank is then read out
// column by column through a valid/ready output register.
// Optional feature macro: TILE_TRANSPOSER_ZERO_PAD_EN. When it is defined, lanes at or
// above the tile row count are driven to zero, and a bank is wiped each time it is freed.
module tile_transposer #(
    parameter int BUFFD = 64,
    parameter int NBANK = 2,
    parameter int AW    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               init_pulse,
    input  logic [1:0]         mode,
    input  logic [AW-1:0]      tile_rows,
    input  logic [AW-1:0]      tile_cols,
    input  logic [AW-1:0]      tile_num,
    input  logic [BUFFD*8-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [BUFFD*8-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic               finish
);

    localparam int DW = BUFFD * 8;
    localparam int RW = $clog2(BUFFD);
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

    // Number of lanes per beat for a given element-size code (11 behaves like 8-bit).
    function automatic logic [AW-1:0] lanes_for(input logic [1:0] m);
        case (m)
            2'b01:   return AW'(BUFFD / 2);
            2'b10:   return AW'(BUFFD / 4);
            default: return AW'(BUFFD);
        endcase
    endfunction

    // Zero or oversized tile dimensions fall back to a full beat of lanes.
    function automatic logic [AW-1:0] clamp_dim(input logic [AW-1:0] v, input logic [AW-1:0] ne);
        return ((v == '0) || (v > ne)) ? ne : v;
    endfunction

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
        return (b == BW'(NBANK - 1)) ? '0 : b + BW'(1);
    endfunction

    logic [1:0]    mode_q, mode_d;
    logic [AW-1:0] rows_q, rows_d;
    logic [AW-1:0] cols_q, cols_d;
    logic [AW-1:0] tiles_q, tiles_d;
    logic [AW-1:0] tin_q, tin_d;
    logic [AW-1:0] tout_q, tout_d;
    logic [AW-1:0] wrow_q, wrow_d;
    logic [AW-1:0] rcol_q, rcol_d;
    logic [BW-1:0] wbank_q, wbank_d;
    logic [BW-1:0] rbank_q, rbank_d;
    logic          busy_q, busy_d;
    logic          finish_q, finish_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic [DW-1:0] m_data_q, m_data_d;
    bank_state_e   bank_state_q [NBANK];
    bank_state_e   bank_state_d [NBANK];

    logic          wr_en;
    logic [DW-1:0] col_data;
    logic [DW-1:0] row_word;
    logic          lane_on;
    logic [DW-1:0] bank_mem_q [NBANK][BUFFD];
`ifdef TILE_TRANSPOSER_ZERO_PAD_EN
    logic [NBANK-1:0] clear_bank;
`endif

    // Gather column rcol of the draining bank: lane r takes element rcol of stored row r.
    always_comb begin
        col_data = '0;
        row_word = '0;
        lane_on  = 1'b0;
        for (int r = 0; r < BUFFD; r++) begin
            row_word = bank_mem_q[rbank_q][r];
`ifdef TILE_TRANSPOSER_ZERO_PAD_EN
            lane_on = (AW'(r) < rows_q);
`else
            lane_on = 1'b1;
`endif
            if (lane_on) begin
                if (mode_q == 2'b10) begin
                    if (r < BUFFD / 4)
                        col_data[r*32 +: 32] = row_word[32*int'(rcol_q[RW-1:0]) +: 32];
                end else if (mode_q == 2'b01) begin
                    if (r < BUFFD / 2)
                        col_data[r*16 +: 16] = row_word[16*int'(rcol_q[RW-1:0]) +: 16];
                end else begin
                    col_data[r*8 +: 8] = row_word[8*int'(rcol_q[RW-1:0]) +: 8];
                end
            end
        end
    end

    // Job control, write/read pointers, bank life cycle and output register next state.
    always_comb begin
        mode_d       = mode_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        tiles_d      = tiles_q;
        tin_d        = tin_q;
        tout_d       = tout_q;
        wrow_d       = wrow_q;
        rcol_d       = rcol_q;
        wbank_d      = wbank_q;
        rbank_d      = rbank_q;
        busy_d       = busy_q;
        finish_d     = 1'b0;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;
        bank_state_d = bank_state_q;
        wr_en        = 1'b0;
`ifdef TILE_TRANSPOSER_ZERO_PAD_EN
        clear_bank   = '0;
`endif
        if (init_pulse) begin
            mode_d    = mode;
            rows_d    = clamp_dim(tile_rows, lanes_for(mode));
            cols_d    = clamp_dim(tile_cols, lanes_for(mode));
            tiles_d   = tile_num;
            busy_d    = (tile_num != '0);
            finish_d  = (tile_num == '0);
            tin_d     = '0;
            tout_d    = '0;
            wrow_d    = '0;
            rcol_d    = '0;
            wbank_d   = '0;
            rbank_d   = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            for (int b = 0; b < NBANK; b++) bank_state_d[b] = EMPTY;
`ifdef TILE_TRANSPOSER_ZERO_PAD_EN
            clear_bank = '1;
`endif
        end else if (busy_q) begin
            if (s_valid && s_ready_q) begin
                wr_en = 1'b1;
                if (wrow_q == rows_q - AW'(1)) begin
                    bank_state_d[wbank_q] = FULL;
                    wrow_d  = '0;
                    wbank_d = next_bank(wbank_q);
                    tin_d   = tin_q + AW'(1);
                end else begin
                    bank_state_d[wbank_q] = FILLING;
                    wrow_d = wrow_q + AW'(1);
                end
            end
            if (m_valid_q && m_ready) begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                if (m_last_q) begin
                    tout_d = tout_q + AW'(1);
                    if (tout_q == tiles_q - AW'(1)) begin
                        finish_d = 1'b1;
                        busy_d   = 1'b0;
                    end
                end
            end
            if (bank_state_q[rbank_q] == FULL) begin
                bank_state_d[rbank_q] = DRAINING;
            end else if ((bank_state_q[rbank_q] == DRAINING) && (!m_valid_q || m_ready)) begin
                m_data_d  = col_data;
                m_valid_d = 1'b1;
                m_last_d  = (rcol_q == cols_q - AW'(1));
                if (rcol_q == cols_q - AW'(1)) begin
                    bank_state_d[rbank_q] = EMPTY;
                    rcol_d  = '0;
                    rbank_d = next_bank(rbank_q);
`ifdef TILE_TRANSPOSER_ZERO_PAD_EN
                    clear_bank[rbank_q] = 1'b1;
`endif
                    // A bank already waiting behind this one starts draining right away.
                    if (bank_state_q[next_bank(rbank_q)] == FULL)
                        bank_state_d[next_bank(rbank_q)] = DRAINING;
                end else begin
                    rcol_d = rcol_q + AW'(1);
                end
            end
        end
        s_ready_d = busy_d && ((bank_state_d[wbank_d] == EMPTY) || (bank_state_d[wbank_d] == FILLING))
                    && (tin_d < tiles_d);
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            tiles_q   <= '0;
            tin_q     <= '0;
            tout_q    <= '0;
            wrow_q    <= '0;
            rcol_q    <= '0;
            wbank_q   <= '0;
            rbank_q   <= '0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            for (int b = 0; b < NBANK; b++) bank_state_q[b] <= EMPTY;
        end else begin
            mode_q       <= mode_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            tiles_q      <= tiles_d;
            tin_q        <= tin_d;
            tout_q       <= tout_d;
            wrow_q       <= wrow_d;
            rcol_q       <= rcol_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            bank_state_q <= bank_state_d;
        end
    end

    // Bank storage: plain data array with write enable, no reset needed.
    always_ff @(posedge clk) begin
`ifdef TILE_TRANSPOSER_ZERO_PAD_EN
        for (int b = 0; b < NBANK; b++)
            if (clear_bank[b])
                for (int r = 0; r < BUFFD; r++) bank_mem_q[b][r] <= '0;
`endif
        if (wr_en) bank_mem_q[wbank_q][wrow_q[RW-1:0]] <= s_data;
    end

    assign s_ready = s_ready_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign finish  = finish_q;

endmodule

// File: tb/tb_tile_transposer.sv
// tb_tile_transposer: directed, self-checking bench for tile_transposer.
module tb_tile_transposer;

    localparam int BUFFD = 64;
    localparam int NBANK = 2;
    localparam int AW    = 16;
    localparam int DW    = BUFFD * 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          init_pulse;
    logic [1:0]    mode;
    logic [AW-1:0] tile_rows, tile_cols, tile_num;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          finish;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] in_beats [$];
    logic [DW-1:0] out_data [$];
    bit            out_last [$];
    int            out_edge [$];
    int in_idx, last_in_edge, first_valid_edge, finish_count, finish_edge, stall_viol;
    bit timed_out;

    tile_transposer #(.BUFFD(BUFFD), .NBANK(NBANK), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .init_pulse(init_pulse), .mode(mode),
        .tile_rows(tile_rows), .tile_cols(tile_cols), .tile_num(tile_num),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    // Bytes that the current build guarantees; padding lanes matter only with zero padding.
    function automatic logic [DW-1:0] lane_mask(input int nbytes);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < nbytes; i++) m[i*8 +: 8] = 8'hFF;
`ifdef TILE_TRANSPOSER_ZERO_PAD_EN
        m = '1;
`endif
        return m;
    endfunction

    task automatic clear_capture();
        in_beats.delete();
        out_data.delete();
        out_last.delete();
        out_edge.delete();
        in_idx = 0; last_in_edge = -1; first_valid_edge = -1;
        finish_count = 0; finish_edge = -1; stall_viol = 0; timed_out = 0;
    endtask

    task automatic start_job(input logic [1:0] md, input int r, input int c, input int t);
        mode = md;
        tile_rows = AW'(r);
        tile_cols = AW'(c);
        tile_num = AW'(t);
        init_pulse = 1'b1;
        @(posedge clk); #1;
        init_pulse = 1'b0;
    endtask

    // Cycle-by-cycle producer/consumer; edge 0 is the edge just before the call.
    task automatic run_job(input int vpct, input int rpct, input int ncyc, input bit until_finish);
        logic [DW-1:0] prev_data;
        bit prev_stall;
        int extra;
        bit done;
        prev_stall = 0; extra = -1; done = 0; prev_data = '0;
        for (int cyc = 0; cyc < ncyc && !done; cyc++) begin
            if (finish === 1'b1) begin
                finish_count++;
                finish_edge = cyc;
                if (extra < 0) extra = 2;
            end
            if (m_valid === 1'b1 && first_valid_edge < 0) first_valid_edge = cyc;
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_viol++;
            if (until_finish && extra == 0) begin
                done = 1;
            end else begin
                if (extra > 0) extra--;
                s_valid = (in_idx < in_beats.size()) && ($urandom_range(99) < vpct);
                s_data  = s_valid ? in_beats[in_idx] : '0;
                m_ready = ($urandom_range(99) < rpct);
                if (s_valid && s_ready === 1'b1) begin
                    in_idx++;
                    last_in_edge = cyc + 1;
                end
                if (m_valid === 1'b1 && m_ready) begin
                    out_data.push_back(m_data);
                    out_last.push_back(m_last === 1'b1);
                    out_edge.push_back(cyc + 1);
                end
                prev_stall = (m_valid === 1'b1) && !m_ready;
                prev_data  = m_data;
                @(posedge clk); #1;
            end
        end
        if (until_finish && !done) timed_out = 1;
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic applyStimulus_reset();
        reset_n = 1'b0; init_pulse = 1'b0; mode = '0; tile_rows = '0; tile_cols = '0;
        tile_num = '0; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus_reset();
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_s_ready got=%b exp=0", s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_valid got=%b exp=0", m_valid); end
        total++; if (m_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_last got=%b exp=0", m_last); end
        total++; if (m_data !== '0) begin bad++; $display("[TB] FAIL reset_m_data got=%h exp=0", m_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (finish !== 1'b0) begin bad++; $display("[TB] FAIL reset_finish got=%b exp=0", finish); end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (s_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset got=%b%b exp=00", s_ready, busy); end
    endtask

    task automatic test_basic_8bit();
        logic [DW-1:0] row, exp;
        clear_capture();
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 64; c++) row[c*8 +: 8] = 8'(r ^ c);
            in_beats.push_back(row);
        end
        start_job(2'b00, 64, 64, 1);
        total++; if (busy !== 1'b1 || s_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_start got=%b%b exp=11", busy, s_ready); end
        run_job(100, 100, 2000, 1);
        total++; if (timed_out) begin bad++; $display("[TB] FAIL basic_timeout got=1 exp=0"); end
        total++; if (out_data.size() != 64) begin bad++; $display("[TB] FAIL basic_count got=%0d exp=64", out_data.size()); end
        for (int c = 0; c < out_data.size() && c < 64; c++) begin
            for (int r = 0; r < 64; r++) exp[r*8 +: 8] = 8'(r ^ c);
            total++; if (out_data[c] !== exp) begin bad++; $display("[TB] FAIL basic_data beat=%0d got=%h exp=%h", c, out_data[c], exp); end
            total++; if (out_last[c] != (c == 63)) begin bad++; $display("[TB] FAIL basic_last beat=%0d got=%b exp=%b", c, out_last[c], c == 63); end
        end
        total++; if (first_valid_edge != last_in_edge + 2) begin bad++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", first_valid_edge, last_in_edge + 2); end
        total++; if (out_edge.size() == 64 && finish_edge != out_edge[63]) begin bad++; $display("[TB] FAIL basic_finish_time got=%0d exp=%0d", finish_edge, out_edge[63]); end
        total++; if (finish_count != 1) begin bad++; $display("[TB] FAIL basic_finish_count got=%0d exp=1", finish_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_mode32_pad();
        logic [DW-1:0] row, exp, mask;
        int b;
        clear_capture();
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 16; c++) row[c*32 +: 32] = 32'hA000_0000 | (t << 16) | (r << 8) | c;
                in_beats.push_back(row);
            end
        start_job(2'b10, 5, 3, 2);
        run_job(100, 100, 500, 1);
        mask = lane_mask(20);
        total++; if (timed_out) begin bad++; $display("[TB] FAIL pad_timeout got=1 exp=0"); end
        total++; if (out_data.size() != 6) begin bad++; $display("[TB] FAIL pad_count got=%0d exp=6", out_data.size()); end
        for (int t = 0; t < 2; t++)
            for (int c = 0; c < 3; c++) begin
                b = t * 3 + c;
                if (b < out_data.size()) begin
                    exp = '0;
                    for (int r = 0; r < 5; r++) exp[r*32 +: 32] = 32'hA000_0000 | (t << 16) | (r << 8) | c;
                    total++; if ((out_data[b] & mask) !== (exp & mask)) begin bad++; $display("[TB] FAIL pad_data beat=%0d got=%h exp=%h", b, out_data[b], exp); end
                    total++; if (out_last[b] != (c == 2)) begin bad++; $display("[TB] FAIL pad_last beat=%0d got=%b exp=%b", b, out_last[b], c == 2); end
                end
            end
        total++; if (finish_count != 1) begin bad++; $display("[TB] FAIL pad_finish_count got=%0d exp=1", finish_count); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] row, exp, mask;
        int b;
        clear_capture();
        for (int t = 0; t < 4; t++)
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 64; c++) row[c*8 +: 8] = 8'((t << 6) | (r << 4) | (c & 15));
                in_beats.push_back(row);
            end
        start_job(2'b00, 4, 4, 4);
        run_job(100, 0, 40, 0);
        total++; if (in_idx != NBANK * 4) begin bad++; $display("[TB] FAIL bp_accepted got=%0d exp=%0d", in_idx, NBANK * 4); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_s_ready got=%b exp=0", s_ready); end
        total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_m_valid got=%b exp=1", m_valid); end
        total++; if (stall_viol != 0) begin bad++; $display("[TB] FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
        run_job(100, 100, 3000, 1);
        mask = lane_mask(4);
        total++; if (timed_out) begin bad++; $display("[TB] FAIL bp_timeout got=1 exp=0"); end
        total++; if (out_data.size() != 16) begin bad++; $display("[TB] FAIL bp_count got=%0d exp=16", out_data.size()); end
        for (int t = 0; t < 4; t++)
            for (int c = 0; c < 4; c++) begin
                b = t * 4 + c;
                if (b < out_data.size()) begin
                    exp = '0;
                    for (int r = 0; r < 4; r++) exp[r*8 +: 8] = 8'((t << 6) | (r << 4) | c);
                    total++; if ((out_data[b] & mask) !== (exp & mask)) begin bad++; $display("[TB] FAIL bp_data beat=%0d got=%h exp=%h", b, out_data[b], exp); end
                    total++; if (out_last[b] != (c == 3)) begin bad++; $display("[TB] FAIL bp_last beat=%0d got=%b exp=%b", b, out_last[b], c == 3); end
                end
            end
        total++; if (finish_count != 1) begin bad++; $display("[TB] FAIL bp_finish_count got=%0d exp=1", finish_count); end
    endtask

    task automatic test_random_stall();
        logic [DW-1:0] row, exp;
        int b;
        clear_capture();
        for (int t = 0; t < 8; t++)
            for (int r = 0; r < 32; r++) begin
                for (int c = 0; c < 32; c++) row[c*16 +: 16] = 16'((t << 12) | (r << 6) | c);
                in_beats.push_back(row);
            end
        start_job(2'b01, 32, 32, 8);
        run_job(70, 50, 6000, 1);
        total++; if (timed_out) begin bad++; $display("[TB] FAIL rnd_timeout got=1 exp=0"); end
        total++; if (out_data.size() != 256) begin bad++; $display("[TB] FAIL rnd_count got=%0d exp=256", out_data.size()); end
        for (int t = 0; t < 8; t++)
            for (int c = 0; c < 32; c++) begin
                b = t * 32 + c;
                if (b < out_data.size()) begin
                    for (int r = 0; r < 32; r++) exp[r*16 +: 16] = 16'((t << 12) | (r << 6) | c);
                    total++; if (out_data[b] !== exp) begin bad++; $display("[TB] FAIL rnd_data beat=%0d got=%h exp=%h", b, out_data[b], exp); end
                    total++; if (out_last[b] != (c == 31)) begin bad++; $display("[TB] FAIL rnd_last beat=%0d got=%b exp=%b", b, out_last[b], c == 31); end
                end
            end
        total++; if (stall_viol != 0) begin bad++; $display("[TB] FAIL rnd_stall_stable got=%0d exp=0", stall_viol); end
        total++; if (finish_count != 1) begin bad++; $display("[TB] FAIL rnd_finish_count got=%0d exp=1", finish_count); end
    endtask

    task automatic test_abort();
        logic [DW-1:0] row, exp, mask;
        int first_finishes;
        clear_capture();
        for (int t = 0; t < 4; t++)
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 64; c++) row[c*8 +: 8] = 8'((t << 6) | (r << 4) | (c & 15));
                in_beats.push_back(row);
            end
        start_job(2'b00, 4, 4, 4);
        run_job(100, 100, 12, 0);
        total++; if (m_valid !== 1'b1 || s_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_midjob got=%b%b exp=11", m_valid, s_ready); end
        first_finishes = finish_count;
        clear_capture();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 32; c++) row[c*16 +: 16] = 16'hB000 | 16'(r << 8) | 16'(c);
            in_beats.push_back(row);
        end
        s_valid = 1'b1;
        s_data  = {(DW/8){8'hEE}};
        start_job(2'b01, 3, 2, 1);
        s_valid = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_m_valid got=%b exp=0", m_valid); end
        total++; if (busy !== 1'b1 || finish !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy_finish got=%b%b exp=10", busy, finish); end
        run_job(100, 100, 500, 1);
        mask = lane_mask(6);
        total++; if (timed_out) begin bad++; $display("[TB] FAIL abort_timeout got=1 exp=0"); end
        total++; if (out_data.size() != 2) begin bad++; $display("[TB] FAIL abort_count got=%0d exp=2", out_data.size()); end
        for (int c = 0; c < 2 && c < out_data.size(); c++) begin
            exp = '0;
            for (int r = 0; r < 3; r++) exp[r*16 +: 16] = 16'hB000 | 16'(r << 8) | 16'(c);
            total++; if ((out_data[c] & mask) !== (exp & mask)) begin bad++; $display("[TB] FAIL abort_data beat=%0d got=%h exp=%h", c, out_data[c], exp); end
            total++; if (out_last[c] != (c == 1)) begin bad++; $display("[TB] FAIL abort_last beat=%0d got=%b exp=%b", c, out_last[c], c == 1); end
        end
        total++; if (first_finishes + finish_count != 1) begin bad++; $display("[TB] FAIL abort_finish_count got=%0d exp=1", first_finishes + finish_count); end
    endtask

    task automatic test_zero_tiles();
        int seen_ready, seen_valid, late_finish;
        seen_ready = 0; seen_valid = 0; late_finish = 0;
        start_job(2'b00, 4, 4, 0);
        total++; if (finish !== 1'b1) begin bad++; $display("[TB] FAIL zero_finish got=%b exp=1", finish); end
        total++; if (busy !== 1'b0 || s_ready !== 1'b0) begin bad++; $display("[TB] FAIL zero_idle got=%b%b exp=00", busy, s_ready); end
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (s_ready !== 1'b0) seen_ready++;
            if (m_valid !== 1'b0) seen_valid++;
            if (finish !== 1'b0) late_finish++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        total++; if (seen_ready != 0) begin bad++; $display("[TB] FAIL zero_s_ready got=%0d exp=0", seen_ready); end
        total++; if (seen_valid != 0) begin bad++; $display("[TB] FAIL zero_m_valid got=%0d exp=0", seen_valid); end
        total++; if (late_finish != 0) begin bad++; $display("[TB] FAIL zero_finish_pulse got=%0d exp=0", late_finish); end
    endtask

    initial begin
        test_reset();
        test_basic_8bit();
        test_mode32_pad();
        test_backpressure();
        test_random_stall();
        test_abort();
        test_zero_tiles();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
